pkt_rd_burst_dma: RTL and testbench

- Parametrised Avalon-MM burst read engine that moves one packet, byte range [pkt_begin, pkt_end), from host memory into the capture FIFO.
- Next generation of the capture-path read controller. Adds:
  - configurable data width;
  - splitting into bounded bursts;
  - correct waitrequest/readdatavalid handling;
  - credit-based FIFO backpressure;
  - last-word byte count;
  - error reporting.
- Sits between the control register file (start, pkt_begin, pkt_end) and the packet FIFO write port.

---
 rtl/pkt_rd_burst_dma_if.sv | 60 ++++++
 rtl/pkt_rd_burst_dma.sv | 211 +++++++++++++++++++++
 tb/tb_pkt_rd_burst_dma.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_rd_burst_dma_if.sv
// ---------------------------------------------------------------------------
// pkt_rd_burst_dma_if
//
// Bus bundle for the packet read DMA: the Avalon-MM burst read master and
// the capture FIFO write port.
//
//   Avalon read side (master drives, slave responds):
//     address       byte address of the burst
//     read          read request
//     burstcount    burst length in words
//     waitrequest   slave stall; command held while high
//     readdata      returned data word
//     readdatavalid one returned word per cycle when high
//
//   FIFO write side:
//     fifo_space    free entries reported by the FIFO (credit)
//     fifo_wr       write strobe
//     fifo_data     write data
//     fifo_last     final word of the packet
//     fifo_bytes    valid bytes in the word
//
// Modports: master = DMA engine, slave = memory/FIFO side.
// ---------------------------------------------------------------------------
interface pkt_rd_burst_dma_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int SPACE_W   = 10
);
    localparam int BYTES = DATA_W / 8;
    localparam int BC_W  = $clog2(MAX_BURST) + 1;
    localparam int FB_W  = $clog2(BYTES) + 1;

    logic [ADDR_W-1:0]  address;
    logic               read;
    logic [BC_W-1:0]    burstcount;
    logic               waitrequest;
    logic [DATA_W-1:0]  readdata;
    logic               readdatavalid;

    logic [SPACE_W-1:0] fifo_space;
    logic               fifo_wr;
    logic [DATA_W-1:0]  fifo_data;
    logic               fifo_last;
    logic [FB_W-1:0]    fifo_bytes;

    modport master (
        output address, read, burstcount,
        input  waitrequest, readdata, readdatavalid,
        input  fifo_space,
        output fifo_wr, fifo_data, fifo_last, fifo_bytes
    );

    modport slave (
        input  address, read, burstcount,
        output waitrequest, readdata, readdatavalid,
        output fifo_space,
        input  fifo_wr, fifo_data, fifo_last, fifo_bytes
    );
endinterface

// File: rtl/pkt_rd_burst_dma.sv
// ---------------------------------------------------------------------------
// pkt_rd_burst_dma
//
// Avalon-MM burst read engine that copies one packet, byte range
// [pkt_begin, pkt_end), from host memory into the capture FIFO.
//
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   start           one-cycle request, only honoured in IDLE
//   pkt_begin/end   byte range, captured on start
//   busy            high from the cycle after start until done
//   done            one-cycle completion pulse
//   err             one-cycle pulse with done when the request was rejected
//   state_dbg       current FSM state
//   bus             pkt_rd_burst_dma_if.master (Avalon read + FIFO write)
//
// Handshakes:
//   Avalon command: a command is offered with read=1 and is accepted on the
//   cycle where read=1 and waitrequest=0. address/burstcount/read are held
//   unchanged while waitrequest=1. Read data has no backpressure: every
//   readdatavalid cycle carries one word. FIFO writes have no ready either;
//   overflow is prevented by only issuing a burst when fifo_space covers it
//   plus every word already requested but not yet returned.
// ---------------------------------------------------------------------------
module pkt_rd_burst_dma #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int SPACE_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] pkt_begin,
    input  logic [ADDR_W-1:0] pkt_end,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_dbg,
    pkt_rd_burst_dma_if.master bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int LOG_B = $clog2(BYTES);
    localparam int BC_W  = $clog2(MAX_BURST) + 1;
    localparam int FB_W  = LOG_B + 1;
    // Word counters: up to 2^16-1 words per packet.
    localparam int CNT_W = 17;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] begin_q;
    logic [ADDR_W-1:0] end_q;
    logic              err_q;
    logic [CNT_W-1:0]  words_q;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  received;
    logic [CNT_W-1:0]  inflight;
    logic [FB_W-1:0]   last_bytes_q;

    // ---------------- request validation ----------------
    logic [ADDR_W-1:0] total_c;
    logic [ADDR_W:0]   words_c;
    logic              bad_c;

    always_comb begin
        total_c = end_q - begin_q;
        words_c = ({1'b0, total_c} + (ADDR_W+1)'(BYTES - 1)) >> LOG_B;
        bad_c   = (begin_q[LOG_B-1:0] != '0) ||
                  (end_q < begin_q) ||
                  (words_c > (ADDR_W+1)'(65535));
    end

    // ---------------- next burst candidate ----------------
    // Evaluated on the state as it will be after the current command (if any)
    // is accepted, so a following burst can go out back-to-back.
    logic              acc;
    logic              slot_free;
    logic [31:0]       acc_blen;
    logic [31:0]       issued_n;
    logic [31:0]       inflight_a;
    logic [31:0]       left_n;
    logic [ADDR_W-1:0] addr_n;
    logic [31:0]       bound_n;
    logic [31:0]       space_w;
    logic [31:0]       blen_n;
    logic              qualify;

    always_comb begin
        acc        = bus.read && !bus.waitrequest;
        slot_free  = !bus.read || acc;
        acc_blen   = acc ? 32'(bus.burstcount) : 32'd0;
        issued_n   = 32'(issued) + acc_blen;
        inflight_a = 32'(inflight) + acc_blen;
        left_n     = 32'(words_q) - issued_n;
        addr_n     = begin_q + ADDR_W'(issued_n << LOG_B);
        // Words remaining before the next MAX_BURST*BYTES address boundary.
        bound_n    = 32'(MAX_BURST) - (32'(addr_n >> LOG_B) & 32'(MAX_BURST - 1));
        space_w    = 32'(bus.fifo_space);
        // A burst longer than the FIFO could ever absorb would never
        // qualify, so the length is also clipped to fifo_space.
        blen_n     = 32'(MAX_BURST);
        if (left_n < blen_n)  blen_n = left_n;
        if (bound_n < blen_n) blen_n = bound_n;
        if (space_w < blen_n) blen_n = space_w;
        qualify    = (state == S_ISSUE) && (blen_n != 32'd0) &&
                     (space_w >= blen_n + inflight_a);
    end

    // ---------------- data path helpers ----------------
    logic beat;
    logic is_last_c;

    always_comb begin
        beat      = bus.readdatavalid && (state != S_IDLE);
        is_last_c = (received == words_q - CNT_W'(1));
    end

    // ---------------- sequential ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= S_IDLE;
            begin_q         <= '0;
            end_q           <= '0;
            err_q           <= 1'b0;
            words_q         <= '0;
            issued          <= '0;
            received        <= '0;
            inflight        <= '0;
            last_bytes_q    <= FB_W'(BYTES);
            bus.read        <= 1'b0;
            bus.address     <= '0;
            bus.burstcount  <= '0;
            bus.fifo_wr     <= 1'b0;
            bus.fifo_data   <= '0;
            bus.fifo_last   <= 1'b0;
            bus.fifo_bytes  <= FB_W'(BYTES);
        end else begin
            // Each accepted beat becomes a FIFO write one cycle later.
            bus.fifo_wr    <= beat;
            bus.fifo_last  <= beat && is_last_c;
            bus.fifo_bytes <= (beat && is_last_c) ? last_bytes_q : FB_W'(BYTES);
            if (beat) begin
                bus.fifo_data <= bus.readdata;
                received      <= received + CNT_W'(1);
            end
            inflight <= CNT_W'(inflight_a - (beat ? 32'd1 : 32'd0));
            issued   <= CNT_W'(issued_n);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        begin_q  <= pkt_begin;
                        end_q    <= pkt_end;
                        err_q    <= 1'b0;
                        issued   <= '0;
                        received <= '0;
                        inflight <= '0;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bad_c) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else if (total_c == '0) begin
                        state <= S_DONE;
                    end else begin
                        words_q      <= CNT_W'(words_c);
                        last_bytes_q <= (total_c[LOG_B-1:0] == '0) ?
                                        FB_W'(BYTES) : {1'b0, total_c[LOG_B-1:0]};
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // While stalled by waitrequest the command registers hold.
                    if (slot_free) begin
                        if (qualify) begin
                            bus.read       <= 1'b1;
                            bus.address    <= addr_n;
                            bus.burstcount <= BC_W'(blen_n);
                        end else begin
                            bus.read <= 1'b0;
                            if (left_n == 32'd0) state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (inflight == '0 && received == words_q) state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        state_dbg = state;
        done      = (state == S_DONE);
        err       = (state == S_DONE) && err_q;
        busy      = (state != S_IDLE) && (state != S_DONE);
    end
endmodule

// File: tb/tb_pkt_rd_burst_dma.sv
// ---------------------------------------------------------------------------
// tb_pkt_rd_burst_dma
//
// Directed bench for pkt_rd_burst_dma (DATA_W=32, MAX_BURST=16). A single
// process steps once per falling edge: it checks FIFO writes against an
// expected queue built from the packet's address range, plays an Avalon
// memory slave (optional waitrequest stall, fixed read latency), and checks
// outstanding words against fifo_space. Packets come from a table of
// hand-computed vectors; reset cases are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_pkt_rd_burst_dma;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MAX_BURST = 16;
    localparam int SPACE_W   = 10;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] pkt_begin;
    logic [ADDR_W-1:0] pkt_end;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        state_dbg;

    pkt_rd_burst_dma_if #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .SPACE_W(SPACE_W)
    ) bus ();

    pkt_rd_burst_dma #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .SPACE_W(SPACE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pkt_begin (pkt_begin),
        .pkt_end   (pkt_end),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg),
        .bus       (bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [31:0] pbeg;
        logic [31:0] pend;
        int          space;
        int          lat;
        int          waits;
        bit          err;
        int          bursts;
        logic [31:0] b0a;
        int          b0c;
        logic [31:0] b1a;
        int          b1c;
        int          words;
        int          lb;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    // ---------------- bench state ----------------
    int          checks;
    int          errors;
    int          cyc;
    int          lat;
    int          wait_budget;
    int          outstanding;
    int          wr_cnt;
    int          pkt_words;
    int          pkt_lb;
    int          beat_i;
    bit          no_wr;
    bit          saw_read;
    bit          prev_wait;
    logic [31:0] held_addr;
    logic [4:0]  held_bc;

    logic [DATA_W-1:0] exp_q[$];
    logic [31:0]       log_addr[$];
    int                log_bc[$];
    logic [31:0]       cmd_addr[$];
    int                cmd_bc[$];
    int                cmd_rdy[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory slave + FIFO write checker, once per falling edge.
    task automatic bfm_step();
        logic [DATA_W-1:0] exp_d;
        bit                is_last;
        // FIFO write check
        if (bus.fifo_wr) begin
            if (no_wr) begin
                chk("stale_fifo_wr", 64'(bus.fifo_wr), 64'(0));
            end else if (exp_q.size() == 0) begin
                chk("unexpected_fifo_wr", 64'(bus.fifo_wr), 64'(0));
            end else begin
                wr_cnt++;
                exp_d   = exp_q.pop_front();
                is_last = (wr_cnt == pkt_words);
                chk("fifo_data", 64'(bus.fifo_data), 64'(exp_d));
                chk("fifo_last", 64'(bus.fifo_last), 64'(is_last));
                chk("fifo_bytes", 64'(bus.fifo_bytes), is_last ? 64'(pkt_lb) : 64'(4));
            end
        end
        // Command must hold while stalled
        if (prev_wait) begin
            chk("wait_hold_read", 64'(bus.read), 64'(1));
            chk("wait_hold_addr", 64'(bus.address), 64'(held_addr));
            chk("wait_hold_bc", 64'(bus.burstcount), 64'(held_bc));
        end
        if (bus.read) saw_read = 1'b1;
        if (bus.read && wait_budget > 0) begin
            bus.waitrequest = 1'b1;
            wait_budget--;
        end else begin
            bus.waitrequest = 1'b0;
        end
        prev_wait = bus.read && bus.waitrequest;
        held_addr = bus.address;
        held_bc   = bus.burstcount;
        // Acceptance on the coming rising edge
        if (bus.read && !bus.waitrequest) begin
            log_addr.push_back(bus.address);
            log_bc.push_back(int'(bus.burstcount));
            cmd_addr.push_back(bus.address);
            cmd_bc.push_back(int'(bus.burstcount));
            cmd_rdy.push_back(cyc + lat);
            outstanding += int'(bus.burstcount);
            chk("credit_outstanding_le_space", 64'(outstanding <= int'(bus.fifo_space)), 64'(1));
        end
        // Return data
        bus.readdatavalid = 1'b0;
        if (cmd_addr.size() > 0) begin
            if (cmd_rdy[0] <= cyc) begin
                bus.readdatavalid = 1'b1;
                bus.readdata      = mem_word(cmd_addr[0] + 32'(beat_i) * 32'd4);
                beat_i++;
                outstanding--;
                if (beat_i == cmd_bc[0]) begin
                    beat_i = 0;
                    void'(cmd_addr.pop_front());
                    void'(cmd_bc.pop_front());
                    void'(cmd_rdy.pop_front());
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        bfm_step();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
        chk({tag, "_state"}, 64'(state_dbg), 64'(0));
        chk({tag, "_read"}, 64'(bus.read), 64'(0));
        chk({tag, "_address"}, 64'(bus.address), 64'(0));
        chk({tag, "_burstcount"}, 64'(bus.burstcount), 64'(0));
        chk({tag, "_fifo_wr"}, 64'(bus.fifo_wr), 64'(0));
        chk({tag, "_fifo_last"}, 64'(bus.fifo_last), 64'(0));
        chk({tag, "_fifo_data"}, 64'(bus.fifo_data), 64'(0));
        chk({tag, "_fifo_bytes"}, 64'(bus.fifo_bytes), 64'(4));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int done_cyc;
        bus.fifo_space = SPACE_W'(v.space);
        lat            = v.lat;
        wait_budget    = v.waits;
        pkt_words      = v.words;
        pkt_lb         = v.lb;
        wr_cnt         = 0;
        saw_read       = 1'b0;
        log_addr.delete();
        log_bc.delete();
        for (int k = 0; k < v.words; k++) exp_q.push_back(mem_word(v.pbeg + 32'(k) * 32'd4));
        pkt_begin = v.pbeg;
        pkt_end   = v.pend;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("v%0d_busy_after_start", idx), 64'(busy), 64'(1));
        chk($sformatf("v%0d_no_early_done", idx), 64'(done), 64'(0));
        done_cyc = 0;
        for (int t = 2; t < 3000 && done_cyc == 0; t++) begin
            tick();
            if (done) begin
                done_cyc = t;
                chk($sformatf("v%0d_err", idx), 64'(err), 64'(v.err));
                chk($sformatf("v%0d_busy_at_done", idx), 64'(busy), 64'(0));
            end
        end
        if (done_cyc == 0) begin
            chk($sformatf("v%0d_done_timeout", idx), 64'(0), 64'(1));
        end else begin
            if (v.err || v.words == 0)
                chk($sformatf("v%0d_done_latency", idx), 64'(done_cyc), 64'(2));
            tick();
            chk($sformatf("v%0d_done_pulse", idx), 64'(done), 64'(0));
            chk($sformatf("v%0d_idle", idx), 64'(state_dbg), 64'(0));
        end
        chk($sformatf("v%0d_wr_count", idx), 64'(wr_cnt), 64'(v.words));
        chk($sformatf("v%0d_saw_read", idx), 64'(saw_read), 64'(v.bursts != 0));
        chk($sformatf("v%0d_burst_count", idx), 64'(log_addr.size()), 64'(v.bursts));
        if (v.bursts >= 1 && log_addr.size() >= 1) begin
            chk($sformatf("v%0d_b0_addr", idx), 64'(log_addr[0]), 64'(v.b0a));
            chk($sformatf("v%0d_b0_bc", idx), 64'(log_bc[0]), 64'(v.b0c));
        end
        if (v.bursts >= 2 && log_addr.size() >= 2) begin
            chk($sformatf("v%0d_b1_addr", idx), 64'(log_addr[1]), 64'(v.b1a));
            chk($sformatf("v%0d_b1_bc", idx), 64'(log_bc[1]), 64'(v.b1c));
        end
        chk($sformatf("v%0d_exp_q_empty", idx), 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        for (int k = 0; k < 3; k++) tick();
    endtask

    // ---------------- main test ----------------
    initial begin
        vec_t rv;
        bit   pre_ok;
        checks = 0; errors = 0; cyc = 0;
        lat = 1; wait_budget = 0; outstanding = 0; wr_cnt = 0;
        pkt_words = 0; pkt_lb = 4; beat_i = 0;
        no_wr = 1'b0; saw_read = 1'b0; prev_wait = 1'b0;
        held_addr = '0; held_bc = '0;
        reset = 1'b0; start = 1'b0; pkt_begin = '0; pkt_end = '0;
        bus.waitrequest = 1'b0; bus.readdata = '0; bus.readdatavalid = 1'b0;
        bus.fifo_space = SPACE_W'(64);

        //           begin         end          spc lat wt err nb  b0a          b0c b1a          b1c wds lb
        vecs[0] = '{32'h0000_1000, 32'h0000_1040, 64, 1, 0, 1'b0, 1, 32'h0000_1000, 16, 32'h0,        0, 16, 4};
        vecs[1] = '{32'h0000_1000, 32'h0000_1047, 64, 1, 0, 1'b0, 2, 32'h0000_1000, 16, 32'h0000_1040, 2, 18, 3};
        vecs[2] = '{32'h0000_1038, 32'h0000_1048, 64, 1, 0, 1'b0, 2, 32'h0000_1038, 2,  32'h0000_1040, 2, 4,  4};
        vecs[3] = '{32'h0000_3000, 32'h0000_3040, 5,  3, 0, 1'b0, 4, 32'h0000_3000, 5,  32'h0000_3014, 5, 16, 4};
        vecs[4] = '{32'h0000_2000, 32'h0000_2040, 64, 1, 7, 1'b0, 1, 32'h0000_2000, 16, 32'h0,        0, 16, 4};
        vecs[5] = '{32'h0000_1002, 32'h0000_1010, 64, 1, 0, 1'b1, 0, 32'h0,         0,  32'h0,        0, 0,  4};
        vecs[6] = '{32'h0000_1040, 32'h0000_1040, 64, 1, 0, 1'b0, 0, 32'h0,         0,  32'h0,        0, 0,  4};
        vecs[7] = '{32'h0000_2000, 32'h0000_1000, 64, 1, 0, 1'b1, 0, 32'h0,         0,  32'h0,        0, 0,  4};
        vecs[8] = '{32'h0000_4000, 32'h0000_4001, 64, 2, 0, 1'b0, 1, 32'h0000_4000, 1,  32'h0,        0, 1,  1};
        vecs[9] = '{32'h0000_0000, 32'h0004_0000, 64, 1, 0, 1'b1, 0, 32'h0,         0,  32'h0,        0, 0,  4};

        // Power-on reset
        for (int k = 0; k < 3; k++) tick();
        check_reset_vals("por");
        reset = 1'b1;
        for (int k = 0; k < 2; k++) tick();

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Reset in the middle of a burst: outputs clear next cycle and beats
        // still returning from memory are dropped.
        bus.fifo_space = SPACE_W'(64);
        lat       = 4;
        pkt_words = 16;
        pkt_lb    = 4;
        wr_cnt    = 0;
        for (int k = 0; k < 16; k++) exp_q.push_back(mem_word(32'h5000 + 32'(k) * 32'd4));
        pkt_begin = 32'h5000;
        pkt_end   = 32'h5040;
        start     = 1'b1;
        tick();
        start  = 1'b0;
        pre_ok = 1'b0;
        for (int t = 0; t < 100 && !pre_ok; t++) begin
            tick();
            if (wr_cnt >= 2) pre_ok = 1'b1;
        end
        chk("midrst_writes_started", 64'(pre_ok), 64'(1));
        reset = 1'b0;
        no_wr = 1'b1;
        tick();
        check_reset_vals("midrst");
        reset = 1'b1;
        for (int k = 0; k < 25; k++) tick();
        chk("midrst_still_idle", 64'(state_dbg), 64'(0));
        no_wr = 1'b0;
        exp_q.delete();
        outstanding = 0;

        // Recovery after the abort
        rv = vecs[1];
        run_vec(rv, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
